dmem_arbiter: RTL and testbench

Data-memory access controller for the 5-stage RISC-V core. It sits between the memory stage (`memory_cycle`) and the single-ported data memory, and shares that memory with a secondary debug/loader port. It serialises accesses through a fixed-latency memory, stalls the pipeline while a memory-stage access is outstanding, and returns registered read data with a one-cycle acknowledge to whichever port was granted.

---
 rtl/dmem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Serialises memory-stage and debug accesses onto a single-ported,
//            fixed-latency data memory. Define DMEM_ARB_RR_EN for round-robin
//            tie-break; otherwise the memory-stage port has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_req,
  input  logic              m_we,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  output logic              m_stall,
  output logic              m_ack,
  output logic [DATA_W-1:0] m_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_ISSUE   = 2'd1;
  localparam logic [1:0] c_ST_WAIT    = 2'd2;
  localparam logic [1:0] c_ST_CAPTURE = 2'd3;
  localparam logic       c_GNT_M      = 1'b1;
  localparam logic       c_GNT_D      = 1'b0;
  localparam logic [3:0] c_CNT_LOAD   = 4'(MEM_LAT - 1);
  localparam bit         c_LAT_ONE    = (MEM_LAT == 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [3:0]        r_cnt;
  logic              r_gnt_sel;
  logic              r_we;
  logic              r_m_ack;
  logic              r_d_ack;
  logic [DATA_W-1:0] r_m_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic w_m_elig;
  logic w_d_elig;
  logic w_any_elig;
  logic w_pick_m;
  logic w_grant;
  logic w_load_cnt;
  logic w_capture;

  // A port being acknowledged this cycle is not eligible, so a held request
  // is never granted twice.
  assign w_m_elig   = m_req & ~r_m_ack;
  assign w_d_elig   = d_req & ~r_d_ack;
  assign w_any_elig = w_m_elig | w_d_elig;

`ifdef DMEM_ARB_RR_EN
  assign w_pick_m = w_m_elig & ~(w_d_elig & (r_gnt_sel == c_GNT_M));
`else
  assign w_pick_m = w_m_elig;
`endif

  assign m_stall   = m_req & ~r_m_ack;
  assign m_ack     = r_m_ack;
  assign d_ack     = r_d_ack;
  assign m_rdata   = r_m_rdata;
  assign d_rdata   = r_d_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:    if (w_any_elig) w_state_nxt = c_ST_ISSUE;
      c_ST_ISSUE:   w_state_nxt = c_LAT_ONE ? c_ST_CAPTURE : c_ST_WAIT;
      c_ST_WAIT:    if (r_cnt == 4'd1) w_state_nxt = c_ST_CAPTURE;
      c_ST_CAPTURE: w_state_nxt = c_ST_IDLE;
      default:      w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    w_grant    = 1'b0;
    w_load_cnt = 1'b0;
    w_capture  = 1'b0;
    case (r_state)
      c_ST_IDLE:    w_grant = w_any_elig;
      c_ST_ISSUE: begin
        mem_en     = 1'b1;
        mem_we     = r_we;
        w_load_cnt = 1'b1;
      end
      c_ST_CAPTURE: w_capture = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 4'd0;
      r_gnt_sel   <= c_GNT_D;
      r_we        <= 1'b0;
      r_m_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_m_rdata   <= '0;
      r_d_rdata   <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_m_ack <= 1'b0;
      r_d_ack <= 1'b0;
      if (w_grant) begin
        r_gnt_sel   <= w_pick_m ? c_GNT_M : c_GNT_D;
        r_we        <= w_pick_m ? m_we    : d_we;
        r_mem_addr  <= w_pick_m ? m_addr  : d_addr;
        r_mem_wdata <= w_pick_m ? m_wdata : d_wdata;
      end
      if (w_load_cnt) begin
        r_cnt <= c_CNT_LOAD;
      end else if (r_state == c_ST_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Writes load rdata too; the value is meaningless but harmless.
      if (w_capture) begin
        if (r_gnt_sel == c_GNT_M) begin
          r_m_rdata <= mem_rdata;
          r_m_ack   <= 1'b1;
        end else begin
          r_d_rdata <= mem_rdata;
          r_d_ack   <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Self-checking bench for dmem_arbiter (MEM_LAT=2 main instance,
//            MEM_LAT=1 secondary instance). Honours DMEM_ARB_RR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
  localparam int LAT = 2;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        m_req = 0, m_we = 0, d_req = 0, d_we = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, d_addr = 0, d_wdata = 0;
  logic        m_stall, m_ack, d_ack, mem_en, mem_we;
  logic [31:0] m_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_stall(m_stall), .m_ack(m_ack), .m_rdata(m_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic        l_req = 0;
  logic [31:0] l_addr = 0;
  logic        l_stall, l_ack, l_d_ack, l_en, l_we_o;
  logic [31:0] l_rdata, l_d_rdata, l_addr_o, l_wdata_o, l_mem_rdata;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .m_req(l_req), .m_we(1'b0), .m_addr(l_addr), .m_wdata(32'h0),
    .m_stall(l_stall), .m_ack(l_ack), .m_rdata(l_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_ack(l_d_ack), .d_rdata(l_d_rdata),
    .mem_en(l_en), .mem_we(l_we_o), .mem_addr(l_addr_o),
    .mem_wdata(l_wdata_o), .mem_rdata(l_mem_rdata)
  );

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory environment: read data appears LAT cycles after the mem_en cycle.
  logic [31:0] env_mem [bit [31:0]];
  logic [31:0] rd_pipe [LAT+1];
  logic [31:0] p1 [2];
  assign mem_rdata   = rd_pipe[LAT];
  assign l_mem_rdata = p1[1];

  always @(negedge clk) begin
    if (mem_en && mem_we) env_mem[mem_addr] = mem_wdata;
    if (mem_en && !mem_we)
      rd_pipe[0] <= env_mem.exists(mem_addr) ? env_mem[mem_addr] : dflt(mem_addr);
    else
      rd_pipe[0] <= $urandom;
    for (int i = 1; i <= LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    p1[0] <= l_en ? dflt(l_addr_o) : $urandom;
    p1[1] <= p1[0];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk32(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Transaction-level reference: each grant occupies the memory for LAT+2
  // cycles and completes with an ack at grant+LAT+2.
  logic [31:0] ref_mem [bit [31:0]];
  int          free_at, issue_at, ack_m_at, ack_d_at;
  bit          last_m, pend_we, m_known, d_known, x_we;
  logic [31:0] pend_data, x_m_rdata, x_d_rdata, x_addr, x_wdata;
  bit          s_mack, s_dack, s_stall, s_en, s_lack, s_lstall, s_len;
  logic [31:0] s_mrd, s_drd, s_addr, s_lrd;

  task automatic model_reset();
    free_at = 0; issue_at = -1; ack_m_at = -1; ack_d_at = -1;
    last_m = 0; pend_we = 0; x_we = 0;
    m_known = 1; d_known = 1;
    x_m_rdata = 0; x_d_rdata = 0; x_addr = 0; x_wdata = 0;
  endtask

  task automatic tick();
    bit xm, xd, em, ed, pm;
    @(negedge clk);
    xm = (cyc == ack_m_at);
    xd = (cyc == ack_d_at);
    if (xm) begin
      if (pend_we) m_known = 0; else begin x_m_rdata = pend_data; m_known = 1; end
    end
    if (xd) begin
      if (pend_we) d_known = 0; else begin x_d_rdata = pend_data; d_known = 1; end
    end
    s_mack = m_ack; s_dack = d_ack; s_stall = m_stall; s_en = mem_en;
    s_mrd = m_rdata; s_drd = d_rdata; s_addr = mem_addr;
    s_lack = l_ack; s_lstall = l_stall; s_len = l_en; s_lrd = l_rdata;
    chk1("m_ack", m_ack, xm);
    chk1("d_ack", d_ack, xd);
    chk1("m_stall", m_stall, m_req && !xm);
    chk1("mem_en", mem_en, cyc == issue_at);
    chk1("mem_we", mem_we, (cyc == issue_at) && x_we);
    chk32("mem_addr", mem_addr, x_addr);
    chk32("mem_wdata", mem_wdata, x_wdata);
    if (m_known) chk32("m_rdata", m_rdata, x_m_rdata);
    if (d_known) chk32("d_rdata", d_rdata, x_d_rdata);
    chk1("lat1_d_ack", l_d_ack, 1'b0);
    chk1("lat1_mem_we", l_we_o, 1'b0);
    chk32("lat1_d_rdata", l_d_rdata, 32'h0);
    chk32("lat1_mem_wdata", l_wdata_o, 32'h0);
    if (rst) begin
      model_reset();
    end else if (cyc >= free_at) begin
      em = m_req && !xm;
      ed = d_req && !xd;
      if (em || ed) begin
        pm = em && !(ed && RR && last_m);
        x_we    = pm ? m_we    : d_we;
        x_addr  = pm ? m_addr  : d_addr;
        x_wdata = pm ? m_wdata : d_wdata;
        pend_we = x_we;
        if (x_we) ref_mem[x_addr] = x_wdata;
        else pend_data = ref_mem.exists(x_addr) ? ref_mem[x_addr] : dflt(x_addr);
        issue_at = cyc + 1;
        free_at  = cyc + LAT + 2;
        if (pm) ack_m_at = cyc + LAT + 2; else ack_d_at = cyc + LAT + 2;
        last_m = pm;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic run_single(input bit port_d, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, output int ack_k, output int en_k,
                            output int stall_n, output logic [31:0] rdata);
    ack_k = -1; en_k = -1; stall_n = 0; rdata = 'x;
    if (port_d) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; end
    else        begin m_req = 1; m_we = we; m_addr = addr; m_wdata = wdata; end
    for (int k = 0; k < 20 && ack_k < 0; k++) begin
      tick();
      if (s_en && en_k < 0) en_k = k;
      if (s_stall) stall_n++;
      if (s_mack || s_dack) begin ack_k = k; rdata = port_d ? s_drd : s_mrd; end
    end
    m_req = 0; d_req = 0;
  endtask

  task automatic run_pair(input logic [31:0] ma, input logic [31:0] da,
                          output int m_k, output int d_k);
    m_k = -1; d_k = -1;
    m_req = 1; m_we = 0; m_addr = ma; m_wdata = 32'h1111_0000;
    d_req = 1; d_we = 0; d_addr = da; d_wdata = 32'h2222_0000;
    for (int k = 0; k < 30 && (m_k < 0 || d_k < 0); k++) begin
      tick();
      if (s_mack) begin m_k = k; m_req = 0; end
      if (s_dack) begin d_k = k; d_req = 0; end
    end
    m_req = 0; d_req = 0;
  endtask

  typedef struct {
    bit          port_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          rd_chk;
  } vec_t;

  vec_t        vecs [8];
  int          ak, ek, sn, mk, dk, cnt;
  logic [31:0] rd;

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 0, 32'h0000_0080, 32'h0,         32'h0000_D000, 1};
    vecs[1] = '{0, 1, 32'h0000_0080, 32'h1234_5678, 32'h0,         0};
    vecs[2] = '{0, 0, 32'h0000_0080, 32'h0,         32'h1234_5678, 1};
    vecs[3] = '{1, 0, 32'h0000_0080, 32'h0,         32'h1234_5678, 1};
    vecs[4] = '{1, 1, 32'h0000_0040, 32'hCAFE_F00D, 32'h0,         0};
    vecs[5] = '{0, 0, 32'h0000_0040, 32'h0,         32'hCAFE_F00D, 1};
    vecs[6] = '{0, 0, 32'h0000_0010, 32'h0,         32'h5A5A_0010, 1};
    vecs[7] = '{1, 0, 32'hFFFF_FFFC, 32'h0,         32'hA5A5_FFFC, 1};
    env_mem[32'h80] = 32'h0000_D000;
    ref_mem[32'h80] = 32'h0000_D000;

    repeat (3) @(posedge clk);
    #1 rst = 0;
    model_reset();
    tick();

    for (int i = 0; i < 8; i++) begin
      run_single(vecs[i].port_d, vecs[i].we, vecs[i].addr, vecs[i].wdata, ak, ek, sn, rd);
      chk32("vec_ack_cycle", ak, LAT + 2);
      chk32("vec_en_cycle", ek, 1);
      chk32("vec_stall_cycles", sn, vecs[i].port_d ? 0 : LAT + 2);
      if (vecs[i].rd_chk) chk32("vec_rdata", rd, vecs[i].exp_rd);
    end

    // Tie straight after reset: gnt_sel is debug, so the memory stage wins.
    do_reset();
    run_pair(32'h10, 32'h20, mk, dk);
    chk32("tie1_m_ack", mk, 4);
    chk32("tie1_d_ack", dk, 8);
    run_single(0, 0, 32'h10, 0, ak, ek, sn, rd);
    run_pair(32'h10, 32'h20, mk, dk);
    chk32("tie2_m_ack", mk, RR ? 8 : 4);
    chk32("tie2_d_ack", dk, RR ? 4 : 8);

    // Memory stage re-requests after every ack; its held request is
    // ineligible in its own ack cycle, which lets the debug port in.
    do_reset();
    cnt = 0; dk = -1;
    m_req = 1; m_we = 0; m_addr = 32'h44;
    d_req = 1; d_we = 0; d_addr = 32'h30;
    for (int k = 0; k < 60 && (cnt < 5 || dk < 0); k++) begin
      tick();
      if (s_mack) begin
        cnt++;
        m_addr = m_addr + 32'h4;
        if (cnt >= 5) m_req = 0;
      end
      if (s_dack && dk < 0) begin dk = k; d_req = 0; end
    end
    m_req = 0; d_req = 0;
    chk32("starve_m_acks", cnt, 5);
    chk32("starve_d_ack_cycle", dk, 8);

    // Reset while the load sits in WAIT.
    do_reset();
    m_req = 1; m_we = 0; m_addr = 32'h80;
    tick(); tick();
    rst = 1; tick();
    rst = 0; m_req = 0;
    tick();
    chk1("rst_mid_m_ack", s_mack, 1'b0);
    chk1("rst_mid_mem_en", s_en, 1'b0);
    chk32("rst_mid_mem_addr", s_addr, 32'h0);
    chk32("rst_mid_m_rdata", s_mrd, 32'h0);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin tick(); if (s_mack) cnt++; end
    chk32("rst_mid_no_ack", cnt, 0);
    run_single(0, 0, 32'h80, 0, ak, ek, sn, rd);
    chk32("rst_after_ack_cycle", ak, 4);
    chk32("rst_after_stall", sn, 4);
    chk32("rst_after_rdata", rd, 32'h1234_5678);

    // MEM_LAT=1 instance: single load.
    ak = -1; ek = -1; sn = 0;
    l_req = 1; l_addr = 32'h84;
    for (int k = 0; k < 12 && ak < 0; k++) begin
      tick();
      if (s_len && ek < 0) ek = k;
      if (s_lstall) sn++;
      if (s_lack) begin ak = k; rd = s_lrd; end
    end
    l_req = 0;
    chk32("lat1_en_cycle", ek, 1);
    chk32("lat1_ack_cycle", ak, 3);
    chk32("lat1_stall_cycles", sn, 3);
    chk32("lat1_rdata", rd, 32'h5A5A_0084);

    // Randomised traffic on both ports with occasional resets.
    for (int n = 0; n < 1000; n++) begin
      if (m_req && s_mack) m_req = 0;
      if (d_req && s_dack) d_req = 0;
      if (!m_req && $urandom_range(0, 2) == 0) begin
        m_req = 1; m_we = 1'($urandom_range(0, 1));
        m_addr = 32'($urandom_range(0, 15)) << 2; m_wdata = $urandom;
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1));
        d_addr = 32'($urandom_range(0, 15)) << 2; d_wdata = $urandom;
      end
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 0; m_req = 0; d_req = 0;
    repeat (LAT + 3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
